// File: rtl/router_fsm_np_if.sv
// router_fsm_np_if: control bundle between the router FSM and its surroundings
//
// Parameters
//   NUM_PORTS  number of output ports/FIFOs
//   ADDR_W     width of the header address field
//
// Signals (direction as seen by the FSM, i.e. the slave modport)
//   pkt_valid      in   source packet valid
//   din            in   header address bits (low bits of input byte)
//   parity_done    in   parity byte captured by register block
//   low_pkt_valid  in   pkt_valid fell while in full handling
//   fifo_full      in   full flag of the currently selected FIFO
//   fifo_empty     in   per-port FIFO empty flags
//   soft_rst       in   per-port soft reset (read-timeout) pulses
//   detect_add     out  decoding a header address
//   lfd_state      out  loading the header byte
//   ld_state       out  loading payload
//   full_state     out  stalled on a full FIFO
//   laf_state      out  loading the byte held back by a full FIFO
//   rst_int_reg    out  checking parity
//   write_enb_reg  out  FIFO write enable
//   busy           out  source must hold off
//   addr_q         out  latched destination port
//   pkt_drop       out  one-cycle pulse when a packet is dropped
interface router_fsm_np_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    din;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 full_state;
    logic                 laf_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;
    logic [ADDR_W-1:0]    addr_q;
    logic                 pkt_drop;

    modport master (
        output pkt_valid, din, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_rst,
        input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, addr_q, pkt_drop
    );

    modport slave (
        input  pkt_valid, din, parity_done, low_pkt_valid, fifo_full, fifo_empty, soft_rst,
        output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, addr_q, pkt_drop
    );
endinterface

// File: rtl/router_fsm_np.sv
// router_fsm_np: parametrised router control FSM (header decode, load sequencing, full stalls)
//
// Ports
//   clk     in  clock, all state changes on the rising edge
//   resetn  in  synchronous active-low reset
//   bus     router_fsm_np_if.slave: packet handshake, FIFO flags, soft resets,
//           state-decoded controls, latched address and drop pulse
//
// Parameters
//   NUM_PORTS   number of output FIFOs (1..2**ADDR_W)
//   ADDR_W      header address width
//   WAIT_LIMIT  WAIT_TILL_EMPTY timeout in cycles
//
// Build option
//   ROUTER_WAIT_TIMEOUT_EN  when defined, a packet waiting WAIT_LIMIT cycles for its
//                           FIFO to drain is dropped; otherwise it waits indefinitely.
module router_fsm_np #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 255
) (
    input logic           clk,
    input logic           resetn,
    router_fsm_np_if.slave bus
);
    localparam int SPAN = 2 ** ADDR_W;

    if (NUM_PORTS < 1 || NUM_PORTS > SPAN || WAIT_LIMIT < 1) begin : g_bad_params
        $error("router_fsm_np: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic              drop_r, drop_entry;
    logic [SPAN-1:0]   empty_ext, soft_ext;
    logic              valid_dest, soft_hit, wait_timeout;

    // Pad the per-port flags to the full address span so any address indexes a
    // real bit; addresses past NUM_PORTS read as "not empty" / "no soft reset".
    assign empty_ext  = SPAN'(bus.fifo_empty);
    assign soft_ext   = SPAN'(bus.soft_rst);
    assign valid_dest = {1'b0, bus.din} < (ADDR_W + 1)'(NUM_PORTS);
    assign soft_hit   = (state != DECODE_ADDRESS) && soft_ext[addr_r];

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts completed WAIT_TILL_EMPTY cycles; zero in the first cycle of a wait.
    always_ff @(posedge clk) begin
        if (!resetn || state != WAIT_TILL_EMPTY) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires in the WAIT_LIMIT-th cycle spent waiting.
    assign wait_timeout = (state == WAIT_TILL_EMPTY) && (int'(wait_cnt) + 1 >= WAIT_LIMIT);
`else
    assign wait_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = DECODE_ADDRESS;
        addr_nxt  = addr_r;
        if (soft_hit) begin
            addr_nxt = '0;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    state_nxt = DECODE_ADDRESS;
                    if (bus.pkt_valid) begin
                        addr_nxt  = bus.din;
                        state_nxt = !valid_dest ? DROP_PACKET :
                                    empty_ext[bus.din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
                LOAD_DATA:          state_nxt = bus.fifo_full ? FIFO_FULL_STATE :
                                                !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
                FIFO_FULL_STATE:    state_nxt = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:    state_nxt = bus.parity_done ? DECODE_ADDRESS :
                                                bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
                LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:    state_nxt = empty_ext[addr_r] ? LOAD_FIRST_DATA :
                                                wait_timeout ? DROP_PACKET : WAIT_TILL_EMPTY;
                DROP_PACKET:        state_nxt = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
                default:            state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    // pkt_drop is registered so it coincides with the first DROP_PACKET cycle.
    assign drop_entry = (state_nxt == DROP_PACKET) && (state != DROP_PACKET);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_r <= '0;
            drop_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr_r <= addr_nxt;
            drop_r <= drop_entry;
        end
    end

    assign bus.detect_add    = state == DECODE_ADDRESS;
    assign bus.lfd_state     = state == LOAD_FIRST_DATA;
    assign bus.ld_state      = state == LOAD_DATA;
    assign bus.full_state    = state == FIFO_FULL_STATE;
    assign bus.laf_state     = state == LOAD_AFTER_FULL;
    assign bus.rst_int_reg   = state == CHECK_PARITY_ERROR;
    assign bus.write_enb_reg = state inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY};
    assign bus.busy          = state inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                             LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY};
    assign bus.addr_q        = addr_r;
    assign bus.pkt_drop      = drop_r;
endmodule

// File: tb/tb_router_fsm_np.sv
// tb_router_fsm_np: directed scenarios plus randomized checking against a phase-level model
module tb_router_fsm_np;
    localparam int NP    = 3;
    localparam int AW    = 2;
    localparam int LIMIT = 4;

    // Expected control vectors {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy}
    localparam logic [7:0] O_DEC  = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_FULL = 8'b0001_0001;
    localparam logic [7:0] O_LAF  = 8'b0000_1011;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_CPE  = 8'b0000_0101;
    localparam logic [7:0] O_WAIT = 8'b0000_0001;
    localparam logic [7:0] O_DROP = 8'b0000_0000;

    logic clk = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   miscompares = 0;

    router_fsm_np_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: packet phase by name, destination, drop pulse, cycles spent waiting.
    string           m_ph = "DECODE";
    logic [AW-1:0]   m_addr = '0;
    logic            m_drop = 1'b0;
    int              m_wait = 0;

    function automatic logic [7:0] outs_of(string ph);
        return {ph == "DECODE", ph == "LFD", ph == "LD", ph == "FULL", ph == "LAF", ph == "CPE",
                ph == "LD" || ph == "LAF" || ph == "LP",
                ph == "LFD" || ph == "FULL" || ph == "LAF" || ph == "LP" || ph == "CPE" || ph == "WAIT"};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state, bus.laf_state,
                bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    task automatic model_step();
        string         nx;
        logic [AW-1:0] na;
        int            d;
        nx = m_ph;
        na = m_addr;
        d  = int'(bus.din);
        if (!resetn) begin
            nx = "DECODE";
            na = '0;
        end else if (m_ph != "DECODE" && int'(m_addr) < NP && bus.soft_rst[m_addr]) begin
            nx = "DECODE";
            na = '0;
        end else if (m_ph == "DECODE") begin
            if (bus.pkt_valid) begin
                na = bus.din;
                if (d >= NP) nx = "DROP";
                else nx = bus.fifo_empty[d] ? "LFD" : "WAIT";
            end
        end else if (m_ph == "LFD") nx = "LD";
        else if (m_ph == "LD") begin
            if (bus.fifo_full) nx = "FULL";
            else if (!bus.pkt_valid) nx = "LP";
        end else if (m_ph == "FULL") begin
            if (!bus.fifo_full) nx = "LAF";
        end else if (m_ph == "LAF") begin
            nx = bus.parity_done ? "DECODE" : bus.low_pkt_valid ? "LP" : "LD";
        end else if (m_ph == "LP") nx = "CPE";
        else if (m_ph == "CPE") nx = bus.fifo_full ? "FULL" : "DECODE";
        else if (m_ph == "WAIT") begin
            if (bus.fifo_empty[m_addr]) nx = "LFD";
`ifdef ROUTER_WAIT_TIMEOUT_EN
            else if (m_wait + 1 >= LIMIT) nx = "DROP";
`endif
        end else if (m_ph == "DROP") begin
            if (!bus.pkt_valid) nx = "DECODE";
        end
        m_drop = resetn && nx == "DROP" && m_ph != "DROP";
        m_wait = (m_ph == "WAIT" && nx == "WAIT") ? m_wait + 1 : 0;
        m_ph   = nx;
        m_addr = na;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.din           = '0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = '1;
        bus.soft_rst      = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (observed() !== O_DEC || bus.addr_q !== 2'd0 || bus.pkt_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: outs=%b addr=%0d drop=%b, required outs=%b addr=0 drop=0",
                     observed(), bus.addr_q, bus.pkt_drop, O_DEC);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_normal_packet();
        logic [7:0] exp_o [7] = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DEC};
        logic       pv    [7] = '{1, 1, 1, 1, 0, 0, 0};
        int we = 0;
        idle_inputs();
        bus.din = 2'd2;
        for (int i = 0; i < 7; i++) begin
            bus.pkt_valid = pv[i];
            tick();
            we += int'(bus.write_enb_reg);
            vectors++;
            if (observed() !== exp_o[i]) begin
                miscompares++;
                $display("FAIL normal_packet cycle %0d: outs=%b, required %b", i, observed(), exp_o[i]);
            end
            if (i == 0) begin
                vectors++;
                if (bus.addr_q !== 2'd2) begin
                    miscompares++;
                    $display("FAIL normal_packet addr_q: got %0d, required 2", bus.addr_q);
                end
            end
        end
        vectors++;
        if (we != 4) begin
            miscompares++;
            $display("FAIL normal_packet write_enb cycles: got %0d, required 4", we);
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] exp_o [8] = '{O_LFD, O_LD, O_FULL, O_FULL, O_LAF, O_LP, O_CPE, O_DEC};
        logic [2:0] in_v  [8] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b001, 3'b001, 3'b000, 3'b000};
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            {bus.pkt_valid, bus.fifo_full, bus.low_pkt_valid} = in_v[i];
            tick();
            vectors++;
            if (observed() !== exp_o[i]) begin
                miscompares++;
                $display("FAIL full_stall cycle %0d: outs=%b, required %b", i, observed(), exp_o[i]);
            end
        end
    endtask

    task automatic test_wait_soft_reset();
        idle_inputs();
        bus.din        = 2'd1;
        bus.fifo_empty = 3'b101;
        bus.pkt_valid  = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
        tick();
        vectors++;
        if (observed() !== O_WAIT || bus.addr_q !== 2'd1) begin
            miscompares++;
            $display("FAIL wait_entry: outs=%b addr=%0d, required %b addr=1", observed(), bus.addr_q, O_WAIT);
        end
        bus.soft_rst = 3'b010;
        tick();
        bus.soft_rst = '0;
        vectors++;
        if (observed() !== O_DEC || bus.addr_q !== 2'd0) begin
            miscompares++;
            $display("FAIL soft_rst_match: outs=%b addr=%0d, required %b addr=0", observed(), bus.addr_q, O_DEC);
        end
        bus.pkt_valid = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
        bus.soft_rst  = 3'b001;
        tick();
        bus.soft_rst = '0;
        vectors++;
        if (observed() !== O_WAIT || bus.addr_q !== 2'd1) begin
            miscompares++;
            $display("FAIL soft_rst_other_port: outs=%b addr=%0d, required %b addr=1", observed(), bus.addr_q, O_WAIT);
        end
        bus.fifo_empty = 3'b111;
        tick();
        vectors++;
        if (observed() !== O_LFD) begin
            miscompares++;
            $display("FAIL wait_release: outs=%b, required %b", observed(), O_LFD);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_invalid_address();
        int drops = 0;
        idle_inputs();
        bus.din       = 2'd3;
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            drops += int'(bus.pkt_drop);
            vectors++;
            if (observed() !== O_DROP || bus.pkt_drop !== (i == 0)) begin
                miscompares++;
                $display("FAIL invalid_addr cycle %0d: outs=%b drop=%b, required %b drop=%b",
                         i, observed(), bus.pkt_drop, O_DROP, i == 0);
            end
        end
        bus.pkt_valid = 1'b0;
        tick();
        vectors++;
        if (observed() !== O_DEC || drops != 1) begin
            miscompares++;
            $display("FAIL invalid_addr_exit: outs=%b drops=%0d, required %b drops=1", observed(), drops, O_DEC);
        end
    endtask

    task automatic test_wait_timeout();
        idle_inputs();
        bus.din        = 2'd0;
        bus.fifo_empty = 3'b110;
        bus.pkt_valid  = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (observed() !== O_WAIT) begin
            miscompares++;
            $display("FAIL timeout_4th_wait: outs=%b, required %b", observed(), O_WAIT);
        end
        tick();
        vectors++;
        if (observed() !== O_DROP || bus.pkt_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_drop: outs=%b drop=%b, required %b drop=1", observed(), bus.pkt_drop, O_DROP);
        end
        tick();
        bus.pkt_valid = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.fifo_empty = 3'b111;
        tick();
        vectors++;
        if (observed() !== O_LFD || bus.pkt_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_late_empty: outs=%b drop=%b, required %b drop=0", observed(), bus.pkt_drop, O_LFD);
        end
`else
        for (int i = 0; i < 12; i++) tick();
        vectors++;
        if (observed() !== O_WAIT || bus.pkt_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_no_timeout: outs=%b drop=%b, required %b drop=0", observed(), bus.pkt_drop, O_WAIT);
        end
        bus.fifo_empty = 3'b111;
        tick();
`endif
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid_packet();
        idle_inputs();
        bus.din       = 2'd2;
        bus.pkt_valid = 1'b1;
        tick();
        tick();
        vectors++;
        if (observed() !== O_LD) begin
            miscompares++;
            $display("FAIL reset_mid_setup: outs=%b, required %b", observed(), O_LD);
        end
        resetn = 1'b0;
        tick();
        vectors++;
        if (observed() !== O_DEC || bus.addr_q !== 2'd0 || bus.pkt_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_packet: outs=%b addr=%0d drop=%b, required %b addr=0 drop=0",
                     observed(), bus.addr_q, bus.pkt_drop, O_DEC);
        end
        resetn = 1'b1;
        bus.pkt_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            resetn            = $urandom_range(0, 99) != 0;
            bus.pkt_valid     = $urandom_range(0, 3) != 0;
            bus.din           = AW'($urandom_range(0, 3));
            bus.parity_done   = $urandom_range(0, 4) == 0;
            bus.low_pkt_valid = $urandom_range(0, 2) == 0;
            bus.fifo_full     = $urandom_range(0, 2) == 0;
            bus.fifo_empty    = NP'($urandom);
            bus.soft_rst      = ($urandom_range(0, 19) == 0) ? NP'(1 << $urandom_range(0, NP - 1)) : '0;
            tick();
            vectors++;
            if ({observed(), bus.addr_q, bus.pkt_drop} !== {outs_of(m_ph), m_addr, m_drop}) begin
                miscompares++;
                $display("FAIL random cycle %0d (%s): outs=%b addr=%0d drop=%b, required outs=%b addr=%0d drop=%b",
                         i, m_ph, observed(), bus.addr_q, bus.pkt_drop, outs_of(m_ph), m_addr, m_drop);
            end
        end
        resetn = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_normal_packet();
        test_full_stall();
        test_wait_soft_reset();
        test_invalid_address();
        test_wait_timeout();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised successor to the 3-port router control FSM. Decodes the packet header address, sequences header/payload/parity loading into one of NUM_PORTS output FIFOs, and handles FIFO-full stalls.
- New over the previous generation: generic port count and address width; soft reset keyed to the latched destination port; invalid-address packet dropping; optional wait-state timeout.
- Sits between the router input synchroniser/register block and the per-port FIFOs.

Parameters:
- NUM_PORTS, 3: number of output ports/FIFOs, 1..2**ADDR_W.
- ADDR_W, 2: width of the header address field on din.
- WAIT_LIMIT, 255: WAIT_TILL_EMPTY timeout in cycles. Used only with ROUTER_WAIT_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  source packet valid.
- din  in  ADDR_W  header address bits (low bits of input byte).
- parity_done  in  1  parity byte captured by register block.
- low_pkt_valid  in  1  pkt_valid fell while in full handling.
- fifo_full  in  1  full flag of currently selected FIFO.
- fifo_empty  in  NUM_PORTS  per-port FIFO empty flags.
- soft_rst  in  NUM_PORTS  per-port soft reset (read-timeout) pulses.
- detect_add  out  1  state==DECODE_ADDRESS.
- lfd_state  out  1  state==LOAD_FIRST_DATA.
- ld_state  out  1  state==LOAD_DATA.
- full_state  out  1  state==FIFO_FULL_STATE.
- laf_state  out  1  state==LOAD_AFTER_FULL.
- rst_int_reg  out  1  state==CHECK_PARITY_ERROR.
- write_enb_reg  out  1  LOAD_DATA, LOAD_AFTER_FULL or LOAD_PARITY.
- busy  out  1  LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR or WAIT_TILL_EMPTY.
- addr_q  out  ADDR_W  latched destination port.
- pkt_drop  out  1  one-cycle pulse when a packet is dropped.

Behaviour:
- **Outputs:** all are Moore-decoded from the registered state. They are valid in the cycle after the state register updates.
- **Reset:** resetn=0 at a clk edge forces state=DECODE_ADDRESS, addr_q=0 and pkt_drop=0. Consequently detect_add=1 and all other outputs are 0.
- **addr_q:** loaded with din on every edge where state==DECODE_ADDRESS and pkt_valid=1. It holds otherwise.
- **Soft reset:** takes effect when state!=DECODE_ADDRESS and soft_rst[addr_q]=1.
  - Next state = DECODE_ADDRESS and addr_q is cleared.
  - Has priority over all transitions below; lower priority than resetn.
  - Ignored while in DECODE_ADDRESS.
- **Transitions:**
  - DECODE_ADDRESS, pkt_valid=0: stay.
  - DECODE_ADDRESS, pkt_valid=1 and din>=NUM_PORTS: go to DROP_PACKET; pkt_drop=1 for the next cycle.
  - DECODE_ADDRESS, pkt_valid=1 and fifo_empty[din]=1: go to LOAD_FIRST_DATA.
  - DECODE_ADDRESS, pkt_valid=1 and fifo_empty[din]=0: go to WAIT_TILL_EMPTY.
  - LOAD_FIRST_DATA: always go to LOAD_DATA.
  - LOAD_DATA: fifo_full=1 goes to FIFO_FULL_STATE. Else pkt_valid=0 goes to LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: fifo_full=0 goes to LOAD_AFTER_FULL. Else stay.
  - LOAD_AFTER_FULL: parity_done=1 goes to DECODE_ADDRESS. Else low_pkt_valid=1 goes to LOAD_PARITY. Else go to LOAD_DATA.
  - LOAD_PARITY: always go to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full=1 goes to FIFO_FULL_STATE. Else go to DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 goes to LOAD_FIRST_DATA. Else stay.
  - DROP_PACKET: pkt_valid=0 goes to DECODE_ADDRESS. Else stay.
- **DROP_PACKET:** busy=0 and write_enb_reg=0, so the source drains and no FIFO is written.
- **Undefined state encodings** recover to DECODE_ADDRESS on the next edge.
- **NUM_PORTS==2**ADDR_W:** DROP_PACKET is unreachable but remains legal.

Optional Feature:
- Macro: ROUTER_WAIT_TIMEOUT_EN.
- **Defined:**
  - A cycle counter clears on entry to WAIT_TILL_EMPTY and increments every cycle spent there.
  - When the count reaches WAIT_LIMIT with fifo_empty[addr_q] still 0, next state = DROP_PACKET and pkt_drop pulses.
  - fifo_empty[addr_q]=1 in the same cycle wins and goes to LOAD_FIRST_DATA.
- **Undefined:** no counter; WAIT_TILL_EMPTY waits indefinitely.

Test Plan:
- **Normal packet:** reset, then pkt_valid=1, din=2, fifo_empty=3'b111, pkt_valid=0 after 3 payload cycles.
  - Required state sequence: DECODE, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
  - write_enb_reg=1 for exactly 4 cycles.
- **Full stall:** fifo_full=1 during LD for 2 cycles, then 0, with low_pkt_valid=1.
  - Required: full_state=1 for 2 cycles, laf_state=1 for 1 cycle, then LOAD_PARITY; busy=1 throughout the stall.
- **Wait and soft reset:** din=1 with fifo_empty[1]=0.
  - Required: WAIT_TILL_EMPTY with busy=1.
  - Pulse soft_rst[1] -> DECODE_ADDRESS next edge, addr_q=0.
  - Repeat with soft_rst[0] instead -> remains in WAIT_TILL_EMPTY.
- **Invalid address:** NUM_PORTS=3, din=3, pkt_valid=1 for 5 cycles.
  - Required: pkt_drop=1 for one cycle, write_enb_reg=0 and busy=0 throughout, DECODE_ADDRESS after pkt_valid falls.
- **Timeout (macro on, WAIT_LIMIT=4):** fifo_empty[0] held 0.
  - Required: DROP_PACKET after 4 WAIT cycles.
  - Second run with fifo_empty[0] rising on the 4th cycle -> LOAD_FIRST_DATA, no drop.
- **Reset mid-packet:** resetn=0 during LD -> DECODE_ADDRESS next edge, all outputs at reset values.
